// File: rtl/isl_gen_pkg.sv
// Shared types and constants for the synthetic ISL51002-style stream generator.
package isl_gen_pkg;

  // Test-pattern encodings on pattern_sel.
  typedef enum logic [1:0] {
    PAT_GRAY    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_RAMP    = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Smallest timing the counters are allowed to run with.
  localparam int unsigned HTOTAL_MIN = 16;
  localparam int unsigned VTOTAL_MIN = 4;

  localparam logic [7:0] GRAY_LEVEL = 8'h80;

  // Colour-bar constants, full-scale per channel.
  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_BLACK   = 24'h000000;

  // Bar index 0..7 maps to the standard bar order; anything past the 8th bar is black.
  function automatic rgb_t bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return RGB_WHITE;
      4'd1:    return RGB_YELLOW;
      4'd2:    return RGB_CYAN;
      4'd3:    return RGB_GREEN;
      4'd4:    return RGB_MAGENTA;
      4'd5:    return RGB_RED;
      4'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/isl_stream_gen_if.sv
// Video output bus of the stream generator: pixel data, syncs, DE, field ID, frame marker.
interface isl_stream_gen_if;
  logic [7:0] R_o;
  logic [7:0] G_o;
  logic [7:0] B_o;
  logic       HSYNC_o;
  logic       VSYNC_o;
  logic       DE_o;
  logic       FID_o;
  logic       frame_start_o;

  modport master (
    output R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, FID_o, frame_start_o
  );

  modport slave (
    input R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, FID_o, frame_start_o
  );
endinterface

// File: rtl/isl_gen_pattern.sv
// Test-pattern source: registered active-pixel/line indices and bar tracker,
// plus a combinational lookup giving the pixel for the current counter position.
module isl_gen_pattern
  import isl_gen_pkg::*;
#(
  parameter int H_W = 12,
  parameter int V_W = 11
) (
  input  logic           ISL_PCLK_i,
  input  logic           sys_reset_n,
  input  logic           run_i,
  input  logic           line_end_i,
  input  logic           field_end_i,
  input  logic           h_act_i,
  input  logic           v_act_i,
  input  logic [H_W-1:0] hactive_i,
  input  pattern_e       pattern_sel_i,
  output rgb_t           pix_o
);

  logic [H_W-1:0] x_q, x_d;
  logic [V_W-1:0] y_q, y_d;
  logic [3:0]     bar_idx_q, bar_idx_d;
  logic [H_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [H_W-1:0] bar_w;

  // Bars are hactive/8 wide; counted pixel by pixel so no divider is needed.
  assign bar_w = hactive_i >> 3;

  // Next-state of the pixel/line indices and of the bar tracker.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    x_d       = '0;
    bar_idx_d = '0;
    bar_cnt_d = '0;
    y_d       = y_q;
    if (run_i && h_act_i && !line_end_i) begin
      x_d = x_q + H_W'(1);
      if (bar_cnt_q + H_W'(1) >= bar_w) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 4'd8) ? 4'd8 : bar_idx_q + 4'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + H_W'(1);
        bar_idx_d = bar_idx_q;
      end
    end
    if (!run_i || field_end_i) begin
      y_d = '0;
    end else if (line_end_i) begin
      y_d = v_act_i ? y_q + V_W'(1) : '0;
    end
  end

  // Index registers advance in lock-step with the timing counters.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!sys_reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      bar_idx_q <= '0;
      bar_cnt_q <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      bar_idx_q <= bar_idx_d;
      bar_cnt_q <= bar_cnt_d;
    end
  end

  // Pattern lookup from the current indices; DE gating happens in the top.
  always_comb begin
    pix_o = RGB_BLACK;
    case (pattern_sel_i)
      PAT_GRAY:    pix_o = {GRAY_LEVEL, GRAY_LEVEL, GRAY_LEVEL};
      PAT_BARS:    pix_o = (bar_w == '0) ? RGB_BLACK : bar_color(bar_idx_q);
      PAT_CHECKER: pix_o = (x_q[4] ^ y_q[4]) ? RGB_WHITE : RGB_BLACK;
      PAT_RAMP:    pix_o = {x_q[7:0], x_q[7:0], x_q[7:0]};
      default:     pix_o = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/isl_stream_gen.sv
// Synthetic ISL51002-style digitizer output: programmable H/V timing, sync polarity,
// progressive or interlaced scan and built-in test patterns, all outputs registered.
module isl_stream_gen
  import isl_gen_pkg::*;
#(
  parameter int H_W = 12,
  parameter int V_W = 11
) (
  input  logic           ISL_PCLK_i,
  input  logic           sys_reset_n,
  input  logic           enable,
  input  logic [H_W-1:0] htotal,
  input  logic [H_W-1:0] hactive,
  input  logic [H_W-1:0] hsync_w,
  input  logic [H_W-1:0] hbp,
  input  logic [V_W-1:0] vtotal,
  input  logic [V_W-1:0] vactive,
  input  logic [V_W-1:0] vsync_w,
  input  logic [V_W-1:0] vbp,
  input  logic           interlace,
  input  logic           hs_pol,
  input  logic           vs_pol,
  input  logic [1:0]     pattern_sel,
  isl_stream_gen_if.master vid
);

  // Shadow copy of the configuration, stable for a whole frame.
  logic [H_W-1:0] htotal_q, hactive_q, hsync_w_q, hbp_q;
  logic [V_W-1:0] vtotal_q, vactive_q, vsync_w_q, vbp_q;
  logic           interlace_q, hs_pol_q, vs_pol_q;
  pattern_e       pattern_sel_q;

  logic           enable_q;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           field_q, field_d;

  rgb_t           rgb_q;
  logic           hsync_q, vsync_q, de_q, fid_q, frame_start_q;

  logic           run, latch_cfg;
  logic [H_W-1:0] htot, half_line;
  logic [V_W-1:0] vtot, vlines;
  logic           line_end, field_end, frame_end;
  logic [H_W+1:0] hstart, hend;
  logic [V_W+1:0] vstart, vend;
  logic           h_de, v_de, hs_act, vs_act;
  rgb_t           pix;

  // Enable must be high on two consecutive edges: the first one latches the config.
  assign run       = enable && enable_q;
  assign htot      = (htotal_q < H_W'(HTOTAL_MIN)) ? H_W'(HTOTAL_MIN) : htotal_q;
  assign vtot      = (vtotal_q < V_W'(VTOTAL_MIN)) ? V_W'(VTOTAL_MIN) : vtotal_q;
  assign half_line = htot >> 1;
  // Field 0 takes the odd line of an odd frame.
  assign vlines    = !interlace_q ? vtot
                   : field_q      ? (vtot >> 1)
                   :                (vtot >> 1) + V_W'(vtot[0]);
  assign line_end  = (h_q == htot - H_W'(1));
  assign field_end = line_end && (v_q == vlines - V_W'(1));
  assign frame_end = field_end && (!interlace_q || field_q);
  assign latch_cfg = (enable && !enable_q) || (run && frame_end);

  assign hstart = {2'b00, hsync_w_q} + {2'b00, hbp_q};
  assign hend   = hstart + {2'b00, hactive_q};
  assign vstart = {2'b00, vsync_w_q} + {2'b00, vbp_q};
  assign vend   = vstart + {2'b00, vactive_q};
  // h never reaches htot, so the active window is clipped there automatically.
  assign h_de   = ({2'b00, h_q} >= hstart) && ({2'b00, h_q} < hend);
  assign v_de   = ({2'b00, v_q} >= vstart) && ({2'b00, v_q} < vend);
  assign hs_act = (h_q < hsync_w_q);

  // Field 1 vertical sync spans (0, htot/2) .. (vsync_w, htot/2): the half-line offset.
  always_comb begin
    vs_act = (v_q < vsync_w_q);
    if (field_q) begin
      vs_act = ((v_q != '0) || (h_q >= half_line)) &&
               ((v_q < vsync_w_q) || ((v_q == vsync_w_q) && (h_q < half_line)));
    end
  end

  // Pixel/line/field counter next-state.
  always_comb begin
    h_d     = h_q + H_W'(1);
    v_d     = v_q;
    field_d = field_q;
    if (!run) begin
      h_d     = '0;
      v_d     = '0;
      field_d = 1'b0;
    end else if (line_end) begin
      h_d = '0;
      if (field_end) begin
        v_d     = '0;
        field_d = interlace_q & ~field_q;
      end else begin
        v_d = v_q + V_W'(1);
      end
    end
  end

  // Shadow config capture on enable rise and on the last pixel of every frame.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    // NOTE: the shadow registers are reset too, so timing is defined before the first enable.
    if (!sys_reset_n) begin
      htotal_q      <= '0;
      hactive_q     <= '0;
      hsync_w_q     <= '0;
      hbp_q         <= '0;
      vtotal_q      <= '0;
      vactive_q     <= '0;
      vsync_w_q     <= '0;
      vbp_q         <= '0;
      interlace_q   <= 1'b0;
      hs_pol_q      <= 1'b0;
      vs_pol_q      <= 1'b0;
      pattern_sel_q <= PAT_GRAY;
    end else if (latch_cfg) begin
      htotal_q      <= htotal;
      hactive_q     <= hactive;
      hsync_w_q     <= hsync_w;
      hbp_q         <= hbp;
      vtotal_q      <= vtotal;
      vactive_q     <= vactive;
      vsync_w_q     <= vsync_w;
      vbp_q         <= vbp;
      interlace_q   <= interlace;
      hs_pol_q      <= hs_pol;
      vs_pol_q      <= vs_pol;
      pattern_sel_q <= pattern_e'(pattern_sel);
    end
  end

  // Enable history and timing counters.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      enable_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      field_q  <= 1'b0;
    end else begin
      enable_q <= enable;
      h_q      <= h_d;
      v_q      <= v_d;
      field_q  <= field_d;
    end
  end

  isl_gen_pattern #(
    .H_W (H_W),
    .V_W (V_W)
  ) u_pattern (
    .ISL_PCLK_i    (ISL_PCLK_i),
    .sys_reset_n   (sys_reset_n),
    .run_i         (run),
    .line_end_i    (line_end),
    .field_end_i   (field_end),
    .h_act_i       (h_de),
    .v_act_i       (v_de),
    .hactive_i     (hactive_q),
    .pattern_sel_i (pattern_sel_q),
    .pix_o         (pix)
  );

  // Output stage: one register between counter state and the pins for every signal.
  always_ff @(posedge ISL_PCLK_i or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rgb_q         <= RGB_BLACK;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      fid_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (run) begin
      rgb_q         <= (h_de && v_de) ? pix : RGB_BLACK;
      hsync_q       <= hs_act ? hs_pol_q : ~hs_pol_q;
      vsync_q       <= vs_act ? vs_pol_q : ~vs_pol_q;
      de_q          <= h_de && v_de;
      fid_q         <= field_q;
      frame_start_q <= (h_q == '0) && (v_q == '0) && !field_q;
    end else begin
      // Idle: syncs follow the live polarity inputs so the line sits inactive.
      rgb_q         <= RGB_BLACK;
      hsync_q       <= ~hs_pol;
      vsync_q       <= ~vs_pol;
      de_q          <= 1'b0;
      fid_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vid.R_o           = rgb_q.r;
  assign vid.G_o           = rgb_q.g;
  assign vid.B_o           = rgb_q.b;
  assign vid.HSYNC_o       = hsync_q;
  assign vid.VSYNC_o       = vsync_q;
  assign vid.DE_o          = de_q;
  assign vid.FID_o         = fid_q;
  assign vid.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_isl_stream_gen.sv
// Directed bench for isl_stream_gen: small hand-computed timings, captured frames
// checked at chosen pixel positions and by per-frame signal counts.
module tb_isl_stream_gen;

  localparam int B_HS  = 4;
  localparam int B_VS  = 3;
  localparam int B_DE  = 2;
  localparam int B_FID = 1;
  localparam int B_FS  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] htotal, hactive, hsync_w, hbp;
  logic [10:0] vtotal, vactive, vsync_w, vbp;
  logic        interlace, hs_pol, vs_pol;
  logic [1:0]  pattern_sel;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] cap [0:1999];

  always #5 clk = ~clk;

  isl_stream_gen_if vid ();

  isl_stream_gen dut (
    .ISL_PCLK_i  (clk),
    .sys_reset_n (rst_n),
    .enable      (enable),
    .htotal      (htotal),
    .hactive     (hactive),
    .hsync_w     (hsync_w),
    .hbp         (hbp),
    .vtotal      (vtotal),
    .vactive     (vactive),
    .vsync_w     (vsync_w),
    .vbp         (vbp),
    .interlace   (interlace),
    .hs_pol      (hs_pol),
    .vs_pol      (vs_pol),
    .pattern_sel (pattern_sel),
    .vid         (vid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {R,G,B,HSYNC,VSYNC,DE,FID,frame_start}
  function automatic logic [31:0] sample();
    return {3'b000, vid.R_o, vid.G_o, vid.B_o, vid.HSYNC_o, vid.VSYNC_o,
            vid.DE_o, vid.FID_o, vid.frame_start_o};
  endfunction

  function automatic logic [31:0] rgb_at(input int i);
    return {8'h00, cap[i][28:5]};
  endfunction

  function automatic logic [31:0] flags_at(input int i);
    return {27'd0, cap[i][4:0]};
  endfunction

  function automatic int count_bit(input int lo, input int hi, input int b, input logic v);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap[i][b] == v) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps at least once, then until frame_start_o; checks the number of steps taken.
  task automatic wait_fs(input string tag, input int exp);
    int n = 0;
    do begin
      step();
      n++;
    end while (!vid.frame_start_o && n < 10000);
    check(tag, n, exp);
  endtask

  task automatic capture(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cap[i] = sample();
      step();
    end
  endtask

  task automatic set_cfg(input int ht, input int ha, input int hs, input int hb,
                         input int vt, input int va, input int vs, input int vb,
                         input logic il, input int pat);
    htotal = 12'(ht); hactive = 12'(ha); hsync_w = 12'(hs); hbp = 12'(hb);
    vtotal = 11'(vt); vactive = 11'(va); vsync_w = 11'(vs); vbp = 11'(vb);
    interlace = il; hs_pol = 1'b0; vs_pol = 1'b0; pattern_sel = 2'(pat);
  endtask

  // Idle briefly, raise enable; first frame_start two edges later.
  task automatic start_gen(input string tag);
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    wait_fs(tag, 2);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int de_n, hs_n, vs_n, fs_n;
    set_cfg(40, 24, 4, 6, 11, 6, 2, 1, 1'b0, 0);
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", sample(), 32'h0);
    #20 rst_n = 1'b1;
    step();
    step();
    check("idle_hsync", {31'd0, vid.HSYNC_o}, 32'd1);

    // Progressive, gray: 40x11 frame, active h 10..33, v 3..8.
    start_gen("en_latency");
    check("first_pixel_flags", sample(), 32'h1);
    capture(0, 440);
    check("prog_period", {31'd0, vid.frame_start_o}, 32'd1);
    check("prog_fs_count", count_bit(0, 439, B_FS, 1'b1), 1);
    check("prog_hs_low", count_bit(0, 439, B_HS, 1'b0), 44);
    check("prog_vs_low", count_bit(0, 439, B_VS, 1'b0), 80);
    check("prog_de_frame", count_bit(0, 439, B_DE, 1'b1), 144);
    check("prog_de_line", count_bit(120, 159, B_DE, 1'b1), 24);
    check("gray_first_px", rgb_at(130), 32'h808080);
    check("gray_first_flags", flags_at(130), 32'h1C);
    check("gray_last_px", rgb_at(353), 32'h808080);
    check("pre_active_flags", flags_at(129), 32'h18);
    check("pre_active_rgb", rgb_at(129), 32'h0);
    check("post_vactive_flags", flags_at(370), 32'h18);
    check("sync_both_flags", flags_at(40), 32'h0);
    check("sync_end_flags", flags_at(84), 32'h18);

    // Colour bars, hactive 26: bars 3 px wide, x 24..25 past the last bar.
    set_cfg(40, 26, 4, 6, 11, 6, 2, 1, 1'b0, 1);
    start_gen("en_latency_bars");
    capture(0, 200);
    check("bar_white", rgb_at(132), 32'hFFFFFF);
    check("bar_yellow", rgb_at(133), 32'hFFFF00);
    check("bar_green", rgb_at(139), 32'h00FF00);
    check("bar_blue", rgb_at(150), 32'h0000FF);
    check("bar_black", rgb_at(151), 32'h0);
    check("bar_past_end", rgb_at(155), 32'h0);
    check("bar_past_end_de", flags_at(155), 32'h1C);
    check("bar_de_line", count_bit(120, 159, B_DE, 1'b1), 26);
    check("bar_next_line", rgb_at(173), 32'hFFFF00);

    // Ramp and checker.
    set_cfg(40, 24, 4, 6, 11, 6, 2, 1, 1'b0, 3);
    start_gen("en_latency_ramp");
    capture(0, 200);
    check("ramp_x5", rgb_at(135), 32'h050505);
    check("ramp_x17_y1", rgb_at(187), 32'h111111);
    set_cfg(40, 24, 4, 6, 11, 6, 2, 1, 1'b0, 2);
    start_gen("en_latency_checker");
    capture(0, 200);
    check("checker_x15", rgb_at(145), 32'h0);
    check("checker_x16", rgb_at(146), 32'hFFFFFF);

    // Full-width line 858/720/62/60, 4 lines; pattern change mid-frame held off.
    set_cfg(858, 720, 62, 60, 4, 2, 1, 0, 1'b0, 1);
    start_gen("en_latency_big");
    capture(0, 100);
    pattern_sel = 2'd3;
    capture(100, 1616);
    check("big_hs_low", count_bit(0, 857, B_HS, 1'b0), 62);
    check("big_de_line", count_bit(858, 1715, B_DE, 1'b1), 720);
    check("big_bar_x90", rgb_at(1070), 32'hFFFF00);
    wait_fs("big_frame_rest", 1716);
    capture(0, 1300);
    check("big_ramp_x300", rgb_at(1280), 32'h2C2C2C);

    // Interlaced 40x11: field 0 six lines, field 1 five lines.
    set_cfg(40, 24, 4, 6, 11, 6, 2, 1, 1'b1, 0);
    start_gen("en_latency_ilace");
    capture(0, 441);
    check("ilace_period", {31'd0, cap[440][B_FS]}, 32'd1);
    check("ilace_fs_count", count_bit(0, 439, B_FS, 1'b1), 1);
    check("ilace_fid1_count", count_bit(0, 439, B_FID, 1'b1), 200);
    check("ilace_fid_f0_last", {31'd0, cap[239][B_FID]}, 32'd0);
    check("ilace_fid_f1_first", {31'd0, cap[240][B_FID]}, 32'd1);
    check("ilace_vs_f1_before", {31'd0, cap[259][B_VS]}, 32'd1);
    check("ilace_vs_f1_fall", {31'd0, cap[260][B_VS]}, 32'd0);
    check("ilace_vs_f1_end", {31'd0, cap[339][B_VS]}, 32'd0);
    check("ilace_vs_f1_rise", {31'd0, cap[340][B_VS]}, 32'd1);
    check("ilace_vs_low", count_bit(0, 439, B_VS, 1'b0), 160);
    check("ilace_de_frame", count_bit(0, 439, B_DE, 1'b1), 120);

    // htotal 40 -> 32 mid-frame: current frame keeps 440, next is 32*11.
    set_cfg(40, 24, 4, 6, 11, 6, 2, 1, 1'b0, 0);
    start_gen("en_latency_hchg");
    capture(0, 100);
    htotal = 12'd32;
    wait_fs("htotal_hold", 340);
    wait_fs("htotal_new", 352);

    // Clamp: htotal 8 -> 16, vtotal 2 -> 4.
    set_cfg(8, 4, 2, 2, 2, 2, 1, 0, 1'b0, 0);
    start_gen("en_latency_clamp");
    capture(0, 64);
    check("clamp_period", {31'd0, vid.frame_start_o}, 32'd1);
    check("clamp_hs_low", count_bit(0, 63, B_HS, 1'b0), 8);
    check("clamp_de", count_bit(0, 63, B_DE, 1'b1), 8);

    // Asynchronous reset mid-frame, then restart with enable held high.
    set_cfg(40, 24, 4, 6, 11, 6, 2, 1, 1'b0, 0);
    start_gen("en_latency_rst");
    capture(0, 215);
    check("pre_reset_de", {31'd0, vid.DE_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("reset_async", sample(), 32'h0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();
    check("rst_e0_fs", {31'd0, vid.frame_start_o}, 32'd0);
    step();
    check("rst_e1_fs", {31'd0, vid.frame_start_o}, 32'd1);

    // Enable low: idle for 1000 clocks.
    enable = 1'b0;
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      de_n += int'(vid.DE_o);
      hs_n += int'(vid.HSYNC_o);
      vs_n += int'(vid.VSYNC_o);
      fs_n += int'(vid.frame_start_o);
    end
    check("idle_de", de_n, 0);
    check("idle_hs_high", hs_n, 1000);
    check("idle_vs_high", vs_n, 1000);
    check("idle_fs", fs_n, 0);
    hs_pol = 1'b1;
    step();
    check("idle_pol_live", {31'd0, vid.HSYNC_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
